microseq_unit: RTL and testbench

- Parametrised microcoded sequencer; successor to the fixed-width control unit.
- Single-edge design with a writable internal microcode store, explicit halt/resume, and an overflow fault.
- Sits between bus/ALU flags and datapath controls. Each cycle it issues one registered control word, looked up by {step, opcode, flags}.

---
 rtl/microseq_pkg.sv | 29 ++
 rtl/microseq_unit_store.sv | 23 ++
 rtl/microseq_unit.sv | 116 +++++++++++
 tb/tb_microseq_unit.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/microseq_pkg.sv
// Shared types, microword field positions and address helper for the microcoded sequencer.
// Optional single-step support is enabled with MICROSEQ_SINGLE_STEP_EN (see microseq_unit).
package microseq_pkg;

  typedef enum logic [1:0] {
    HALTED = 2'd0,
    RUN    = 2'd1,
    FAULT  = 2'd2
  } seq_state_e;

  localparam int MW_END      = 0;
  localparam int MW_LOAD_OPC = 1;
  localparam int MW_HALT     = 2;
  localparam int MW_CTRL_LSB = 3;

  // Packs {step, opcode, flags}; the caller truncates to its address width.
  function automatic logic [31:0] mc_addr_f(
    input logic [31:0] step_v,
    input logic [31:0] opc_v,
    input logic [31:0] flg_v,
    input int          opc_w,
    input int          flag_w
  );
    return (step_v << (opc_w + flag_w))
         | (opc_v << flag_w)
         | flg_v;
  endfunction

endpackage

// File: rtl/microseq_unit_store.sv
// Microcode store: synchronous write, combinational read, no reset.
// Ports: clock, we/waddr/wdata write side, raddr -> rdata read side.
module microseq_unit_store #(
  parameter int AW = 10,
  parameter int DW = 19
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/microseq_unit.sv
// Microcoded sequencer: issues one registered control word per cycle from {step, opcode, flags}.
// Ports: clock, reset (sync, active-low), bus, flags, resume, mc_we/mc_addr/mc_wdata,
//        ctrl, instr_done, halted, fault, step. Macro MICROSEQ_SINGLE_STEP_EN adds
//        step_req and mode_step (RUN advances only on step_req while mode_step is high).
module microseq_unit
  import microseq_pkg::*;
#(
  parameter int STEP_W = 4,
  parameter int OPC_W  = 4,
  parameter int FLAG_W = 2,
  parameter int CTRL_W = 16,
  parameter int BUS_W  = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [BUS_W-1:0]              bus,
  input  logic [FLAG_W-1:0]             flags,
  input  logic                          resume,
  input  logic                          mc_we,
  input  logic [STEP_W+OPC_W+FLAG_W-1:0] mc_addr,
  input  logic [CTRL_W+2:0]             mc_wdata,
`ifdef MICROSEQ_SINGLE_STEP_EN
  input  logic                          step_req,
  input  logic                          mode_step,
`endif
  output logic [CTRL_W-1:0]             ctrl,
  output logic                          instr_done,
  output logic                          halted,
  output logic                          fault,
  output logic [STEP_W-1:0]             step
);

  localparam int AW = STEP_W + OPC_W + FLAG_W;
  localparam int WW = CTRL_W + 3;

  seq_state_e        state;
  logic [OPC_W-1:0]  opcode;
  logic [AW-1:0]     rd_addr;
  logic [WW-1:0]     word;
  logic              advance;
  logic              ovf;
  logic              unused_bus;

  assign unused_bus = ^bus;

`ifdef MICROSEQ_SINGLE_STEP_EN
  assign advance = !mode_step || step_req;
`else
  assign advance = 1'b1;
`endif

  assign rd_addr = AW'(mc_addr_f(32'(step), 32'(opcode),
                                 32'(flags), OPC_W, FLAG_W));

  microseq_unit_store #(
    .AW (AW),
    .DW (WW)
  ) u_store (
    .clock (clock),
    .we    (mc_we && (state != RUN)),
    .waddr (mc_addr),
    .wdata (mc_wdata),
    .raddr (rd_addr),
    .rdata (word)
  );

  // Running off the last step without END or HALT is a fault.
  assign ovf = !word[MW_END] && !word[MW_HALT]
            && (step == {STEP_W{1'b1}});

  assign halted = (state == HALTED);
  assign fault  = (state == FAULT);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= HALTED;
      step       <= '0;
      opcode     <= '0;
      ctrl       <= '0;
      instr_done <= 1'b0;
    end else begin
      ctrl       <= '0;
      instr_done <= 1'b0;
      unique case (state)
        HALTED: begin
          if (resume) state <= RUN;
        end
        RUN: begin
          if (advance) begin
            if (ovf) begin
              state <= FAULT;
            end else begin
              ctrl       <= word[MW_CTRL_LSB +: CTRL_W];
              instr_done <= word[MW_END];
              if (word[MW_LOAD_OPC])
                opcode <= bus[OPC_W-1:0];
              if (word[MW_END])
                step <= '0;
              else
                step <= step + STEP_W'(1);
              if (word[MW_HALT])
                state <= HALTED;
            end
          end
        end
        FAULT: begin
          state <= FAULT;
        end
        default: begin
          state <= FAULT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_microseq_unit.sv
// Scoreboard bench for microseq_unit: stimulus queues expectations, a negedge monitor checks them.
// Build with MICROSEQ_SINGLE_STEP_EN to also exercise single-step mode.
module tb_microseq_unit;

  logic        clock;
  logic        reset;
  logic [7:0]  bus;
  logic [1:0]  flags;
  logic        resume;
  logic        mc_we;
  logic [9:0]  mc_addr;
  logic [18:0] mc_wdata;
  logic [15:0] ctrl;
  logic        instr_done;
  logic        halted;
  logic        fault;
  logic [3:0]  step;
`ifdef MICROSEQ_SINGLE_STEP_EN
  logic        step_req;
  logic        mode_step;
`endif

  microseq_unit dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .flags      (flags),
    .resume     (resume),
    .mc_we      (mc_we),
    .mc_addr    (mc_addr),
    .mc_wdata   (mc_wdata),
`ifdef MICROSEQ_SINGLE_STEP_EN
    .step_req   (step_req),
    .mode_step  (mode_step),
`endif
    .ctrl       (ctrl),
    .instr_done (instr_done),
    .halted     (halted),
    .fault      (fault),
    .step       (step)
  );

  typedef struct {
    int          cyc;
    string       name;
    logic [15:0] ctrl;
    logic        done;
    logic [3:0]  step;
    logic        halted;
    logic        fault;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   tests = 0;
  int   failed = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      tests++;
      if (e.cyc != cyc ||
          {ctrl, instr_done, step, halted, fault} !==
          {e.ctrl, e.done, e.step, e.halted, e.fault}) begin
        failed++;
        $display("FAIL %s cyc=%0d got ctrl=%h done=%b step=%0d halted=%b fault=%b want ctrl=%h done=%b step=%0d halted=%b fault=%b",
                 e.name, cyc, ctrl, instr_done, step, halted, fault,
                 e.ctrl, e.done, e.step, e.halted, e.fault);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_at(input int off, input string nm,
                           input logic [15:0] c, input logic d,
                           input logic [3:0] s, input logic h,
                           input logic f);
    exp_t e;
    e.cyc    = cyc + off;
    e.name   = nm;
    e.ctrl   = c;
    e.done   = d;
    e.step   = s;
    e.halted = h;
    e.fault  = f;
    q.push_back(e);
  endtask

  function automatic logic [9:0] ma(input int s, input int o, input int f);
    return {4'(s), 4'(o), 2'(f)};
  endfunction

  function automatic logic [18:0] mw(input logic [15:0] c, input logic h,
                                     input logic l, input logic e);
    return {c, h, l, e};
  endfunction

  task automatic wr(input logic [9:0] a, input logic [18:0] d);
    mc_we    = 1'b1;
    mc_addr  = a;
    mc_wdata = d;
    tick();
    mc_we    = 1'b0;
  endtask

  task automatic pulse_resume();
    resume = 1'b1;
    tick();
    resume = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    reset    = 1'b0;
    bus      = '0;
    flags    = '0;
    resume   = 1'b0;
    mc_we    = 1'b0;
    mc_addr  = '0;
    mc_wdata = '0;
`ifdef MICROSEQ_SINGLE_STEP_EN
    step_req  = 1'b0;
    mode_step = 1'b0;
`endif
    tick();
    tick();
    expect_at(0, "reset", 16'h0, 0, 0, 1, 0);
    reset = 1'b1;
    tick();
    expect_at(0, "idle_halted", 16'h0, 0, 0, 1, 0);

    wr(ma(0, 0, 0), mw(16'h0001, 0, 1, 0));
    wr(ma(1, 3, 0), mw(16'h00F0, 0, 0, 1));
    wr(ma(0, 3, 0), mw(16'h0003, 1, 0, 1));
    wr(ma(0, 3, 1), mw(16'h1111, 1, 0, 1));
    wr(ma(0, 3, 2), mw(16'h2222, 1, 0, 1));
    wr(ma(0, 3, 3), mw(16'h0033, 0, 1, 0));
    wr(ma(1, 5, 3), mw(16'h0501, 0, 0, 0));
    wr(ma(2, 5, 3), mw(16'h0502, 1, 0, 0));
    wr(ma(3, 5, 3), mw(16'h0503, 0, 0, 0));
    wr(ma(4, 5, 3), mw(16'h0504, 0, 0, 1));
    wr(ma(0, 5, 3), mw(16'h0005, 1, 0, 1));
    wr(ma(0, 5, 2), mw(16'h0070, 0, 1, 0));
    for (int s = 1; s < 16; s++)
      wr(ma(s, 7, 2), mw(16'h7000 | 16'(s), 0, 0, 0));
    wr(ma(0, 0, 2), mw(16'h0002, 0, 1, 0));

    // basic two-word instruction, then END+HALT
    flags = 2'd0;
    bus   = 8'h03;
    pulse_resume();
    expect_at(1, "t1_load",    16'h0001, 0, 1, 0, 0);
    expect_at(2, "t1_end",     16'h00F0, 1, 0, 0, 0);
    expect_at(3, "t1_endhalt", 16'h0003, 1, 0, 1, 0);
    expect_at(4, "t1_halted",  16'h0000, 0, 0, 1, 0);
    repeat (4) tick();

    // flag-selected words
    flags = 2'd1;
    pulse_resume();
    expect_at(1, "t2_flag01", 16'h1111, 1, 0, 1, 0);
    tick();
    flags = 2'd2;
    pulse_resume();
    expect_at(1, "t2_flag10", 16'h2222, 1, 0, 1, 0);
    tick();

    // HALT mid-instruction, write during RUN ignored
    flags = 2'd3;
    bus   = 8'h05;
    pulse_resume();
    mc_we    = 1'b1;
    mc_addr  = ma(3, 5, 3);
    mc_wdata = mw(16'hDEAD, 0, 0, 1);
    expect_at(1, "t3_load5",  16'h0033, 0, 1, 0, 0);
    expect_at(2, "t3_s1",     16'h0501, 0, 2, 0, 0);
    expect_at(3, "t3_halt",   16'h0502, 0, 3, 1, 0);
    expect_at(4, "t3_halted", 16'h0000, 0, 3, 1, 0);
    tick();
    mc_we = 1'b0;
    repeat (3) tick();
    pulse_resume();
    expect_at(1, "t3_resume",  16'h0503, 0, 4, 0, 0);
    expect_at(2, "t3_end",     16'h0504, 1, 0, 0, 0);
    expect_at(3, "t3_endhalt", 16'h0005, 1, 0, 1, 0);
    repeat (3) tick();

    // step overflow -> sticky fault
    flags = 2'd2;
    bus   = 8'h07;
    pulse_resume();
    expect_at(1, "t4_load7", 16'h0070, 0, 1, 0, 0);
    for (int k = 2; k <= 15; k++)
      expect_at(k, "t4_step", 16'h7000 | 16'(k - 1), 0, 4'(k), 0, 0);
    expect_at(16, "t4_fault", 16'h0000, 0, 15, 0, 1);
    repeat (16) tick();
    pulse_resume();
    expect_at(1, "t4_stuck", 16'h0000, 0, 15, 0, 1);
    tick();

    // reset clears fault, store persists
    reset = 1'b0;
    tick();
    expect_at(0, "t5_reset", 16'h0000, 0, 0, 1, 0);
    reset = 1'b1;
    flags = 2'd0;
    bus   = 8'h03;
    pulse_resume();
    expect_at(1, "t5_persist", 16'h0001, 0, 1, 0, 0);
    expect_at(2, "t5_end",     16'h00F0, 1, 0, 0, 0);
    expect_at(3, "t5_endhalt", 16'h0003, 1, 0, 1, 0);
    repeat (3) tick();

    // reset while running at step 6
    reset = 1'b0;
    tick();
    reset = 1'b1;
    flags = 2'd2;
    bus   = 8'h07;
    pulse_resume();
    expect_at(1, "t6_load", 16'h0002, 0, 1, 0, 0);
    for (int k = 2; k <= 6; k++)
      expect_at(k, "t6_step", 16'h7000 | 16'(k - 1), 0, 4'(k), 0, 0);
    repeat (6) tick();
    reset = 1'b0;
    tick();
    expect_at(0, "t6_reset", 16'h0000, 0, 0, 1, 0);
    reset = 1'b1;
    expect_at(1, "t6_hold", 16'h0000, 0, 0, 1, 0);
    tick();

`ifdef MICROSEQ_SINGLE_STEP_EN
    begin
      logic [15:0] pc [3];
      int          pulses;
      pc[0] = 16'h0002;
      pc[1] = 16'h7001;
      pc[2] = 16'h7002;
      pulses = 0;
      mode_step = 1'b1;
      flags = 2'd2;
      bus   = 8'h07;
      pulse_resume();
      for (int c = 0; c < 14; c++) begin
        step_req = (c % 4 == 3) && (pulses < 3);
        if (step_req) begin
          expect_at(1, "t7_pulse", pc[pulses], 0, 4'(pulses + 1), 0, 0);
          pulses++;
        end else begin
          expect_at(1, "t7_idle", 16'h0000, 0, 4'(pulses), 0, 0);
        end
        tick();
      end
      step_req  = 1'b0;
      mode_step = 1'b0;
      reset = 1'b0;
      tick();
      reset = 1'b1;
    end
`endif

    repeat (5) tick();
    if (q.size() != 0) begin
      failed++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
